// File: rtl/rvc_compressor_packer_if.sv
// Stream bundle for the RVC compactor: instruction input side and packed-word output side.
interface rvc_compressor_packer_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_word;
   logic        out_last;

   modport master (
      output in_valid, in_instr, in_last, out_ready,
      input  in_ready, out_valid, out_word, out_last
   );

   modport slave (
      input  in_valid, in_instr, in_last, out_ready,
      output in_ready, out_valid, out_word, out_last
   );
endinterface

// File: rtl/rvc_compressor_packer.sv
// Streaming RV32C compactor: replaces RV32I instructions by RVC equivalents where possible
// and packs the resulting 16/32-bit parcels little-endian into 32-bit words.
module rvc_compressor_packer #(
   parameter bit          ENABLE_COMPRESS = 1'b1,
   parameter int unsigned CNT_W           = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   rvc_compressor_packer_if.slave bus,
   output logic [CNT_W-1:0]       cnt_total,
   output logic [CNT_W-1:0]       cnt_comp
);
   typedef enum logic [0:0] {StRun, StFlush} state_e;

   state_e            state_q, state_d;
   logic              out_valid_q, out_valid_d;
   logic [31:0]       out_word_q, out_word_d;
   logic              out_last_q, out_last_d;
   logic [15:0]       hold_q, hold_d;
   logic              hold_valid_q, hold_valid_d;
   logic [CNT_W-1:0]  cnt_total_q, cnt_total_d;
   logic [CNT_W-1:0]  cnt_comp_q, cnt_comp_d;

   logic [31:0] ins;
   logic [6:0]  opc, f7;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  f3;
   logic        rd_p, rs1_p, rs2_p, imm6_ok;
   logic        c_ok, is_c, ca_hit;
   logic [1:0]  ca_op;
   logic [15:0] c_half;
   logic        slot_free, xfer;

   assign ins     = bus.in_instr;
   assign opc     = ins[6:0];
   assign rd      = ins[11:7];
   assign f3      = ins[14:12];
   assign rs1     = ins[19:15];
   assign rs2     = ins[24:20];
   assign f7      = ins[31:25];
   assign rd_p    = (rd[4:3] == 2'b01);
   assign rs1_p   = (rs1[4:3] == 2'b01);
   assign rs2_p   = (rs2[4:3] == 2'b01);
   // I-immediate fits a signed 6-bit field
   assign imm6_ok = (ins[31:25] == {7{ins[25]}});

   always_comb begin
      c_ok   = 1'b0;
      c_half = 16'h0000;
      ca_hit = 1'b1;
      ca_op  = 2'b00;
      if (f3 == 3'b000 && f7 == 7'b0100000)      ca_op = 2'b00;
      else if (f3 == 3'b100 && f7 == 7'b0000000) ca_op = 2'b01;
      else if (f3 == 3'b110 && f7 == 7'b0000000) ca_op = 2'b10;
      else if (f3 == 3'b111 && f7 == 7'b0000000) ca_op = 2'b11;
      else                                       ca_hit = 1'b0;
      case (opc)
         7'b0010011: begin
            case (f3)
               3'b000: begin
                  if (rd == 5'd0 && rs1 == 5'd0 && ins[31:20] == 12'd0) begin
                     c_ok = 1'b1; c_half = 16'h0001;
                  end else if (rd != 5'd0 && rs1 == rd && imm6_ok && ins[31:20] != 12'd0) begin
                     c_ok = 1'b1; c_half = {3'b000, ins[25], rd, ins[24:20], 2'b01};
                  end else if (rd != 5'd0 && rs1 == 5'd0 && imm6_ok) begin
                     c_ok = 1'b1; c_half = {3'b010, ins[25], rd, ins[24:20], 2'b01};
                  end
               end
               3'b111: if (rd_p && rs1 == rd && imm6_ok) begin
                  c_ok = 1'b1; c_half = {3'b100, ins[25], 2'b10, rd[2:0], ins[24:20], 2'b01};
               end
               3'b101: if (rd_p && rs1 == rd && rs2 != 5'd0 &&
                           (f7 == 7'b0000000 || f7 == 7'b0100000)) begin
                  c_ok = 1'b1; c_half = {3'b100, 1'b0, 1'b0, f7[5], rd[2:0], rs2, 2'b01};
               end
               3'b001: if (rd != 5'd0 && rs1 == rd && rs2 != 5'd0 && f7 == 7'b0000000) begin
                  c_ok = 1'b1; c_half = {3'b000, 1'b0, rd, rs2, 2'b10};
               end
               default: ;
            endcase
         end
         7'b0110011: begin
            if (f3 == 3'b000 && f7 == 7'b0000000 && rd != 5'd0 && rs2 != 5'd0 && rs1 == 5'd0) begin
               c_ok = 1'b1; c_half = {4'b1000, rd, rs2, 2'b10};
            end else if (f3 == 3'b000 && f7 == 7'b0000000 && rd != 5'd0 && rs2 != 5'd0 &&
                         rs1 == rd) begin
               c_ok = 1'b1; c_half = {4'b1001, rd, rs2, 2'b10};
            end else if (ca_hit && rd_p && rs2_p && rs1 == rd) begin
               c_ok = 1'b1; c_half = {6'b100011, rd[2:0], ca_op, rs2[2:0], 2'b01};
            end
         end
         7'b0000011: if (f3 == 3'b010) begin
            if (rs1_p && rd_p && ins[31:27] == 5'd0 && ins[21:20] == 2'd0) begin
               c_ok = 1'b1;
               c_half = {3'b010, ins[25:23], rs1[2:0], ins[22], ins[26], rd[2:0], 2'b00};
            end else if (rs1 == 5'd2 && rd != 5'd0 && ins[31:28] == 4'd0 && ins[21:20] == 2'd0) begin
               c_ok = 1'b1; c_half = {3'b010, ins[25], rd, ins[24:22], ins[27:26], 2'b10};
            end
         end
         7'b0100011: if (f3 == 3'b010) begin
            if (rs1_p && rs2_p && ins[31:27] == 5'd0 && ins[8:7] == 2'd0) begin
               c_ok = 1'b1;
               c_half = {3'b110, ins[25], ins[11:10], rs1[2:0], ins[9], ins[26], rs2[2:0], 2'b00};
            end else if (rs1 == 5'd2 && ins[31:28] == 4'd0 && ins[8:7] == 2'd0) begin
               c_ok = 1'b1; c_half = {3'b110, ins[25], ins[11:9], ins[27:26], rs2, 2'b10};
            end
         end
         7'b1101111: if (rd[4:1] == 4'd0 && ins[20:12] == {9{ins[31]}}) begin
            c_ok = 1'b1;
            c_half = {~rd[0], 2'b01, ins[20], ins[24], ins[29:28], ins[30], ins[26], ins[27],
                      ins[23:21], ins[25], 2'b01};
         end
         7'b1100011: if (f3[2:1] == 2'b00 && rs2 == 5'd0 && rs1_p &&
                         ins[30:28] == {3{ins[31]}} && ins[7] == ins[31]) begin
            c_ok = 1'b1;
            c_half = {2'b11, f3[0], ins[28], ins[11:10], rs1[2:0], ins[27:26], ins[9:8], ins[25],
                      2'b01};
         end
         default: ;
      endcase
   end

   assign is_c         = ENABLE_COMPRESS && c_ok;
   assign slot_free    = !out_valid_q || bus.out_ready;
   assign bus.in_ready = (state_q == StRun) && slot_free;
   assign xfer         = bus.in_valid && bus.in_ready;

   always_comb begin
      state_d      = state_q;
      out_valid_d  = out_valid_q && !bus.out_ready;
      out_word_d   = out_word_q;
      out_last_d   = out_last_q;
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      cnt_total_d  = cnt_total_q;
      cnt_comp_d   = cnt_comp_q;
      case (state_q)
         StRun: if (xfer) begin
            if (cnt_total_q != '1) cnt_total_d = cnt_total_q + CNT_W'(1);
            if (is_c && cnt_comp_q != '1) cnt_comp_d = cnt_comp_q + CNT_W'(1);
            if (!hold_valid_q) begin
               if (is_c) begin
                  hold_d       = c_half;
                  hold_valid_d = 1'b1;
               end else begin
                  out_valid_d = 1'b1;
                  out_word_d  = ins;
                  out_last_d  = bus.in_last;
               end
            end else if (is_c) begin
               out_valid_d  = 1'b1;
               out_word_d   = {c_half, hold_q};
               out_last_d   = bus.in_last;
               hold_valid_d = 1'b0;
            end else begin
               // Upper half of a straddling 32-bit instruction becomes the new hold
               out_valid_d = 1'b1;
               out_word_d  = {ins[15:0], hold_q};
               out_last_d  = 1'b0;
               hold_d      = ins[31:16];
            end
            if (bus.in_last && hold_valid_d) state_d = StFlush;
         end
         StFlush: if (slot_free) begin
            out_valid_d  = 1'b1;
            out_word_d   = {16'h0001, hold_q};
            out_last_d   = 1'b1;
            hold_d       = 16'h0000;
            hold_valid_d = 1'b0;
            state_d      = StRun;
         end
         default: state_d = StRun;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= StRun;
         out_valid_q  <= 1'b0;
         out_word_q   <= 32'h0;
         out_last_q   <= 1'b0;
         hold_q       <= 16'h0;
         hold_valid_q <= 1'b0;
         cnt_total_q  <= '0;
         cnt_comp_q   <= '0;
      end else begin
         state_q      <= state_d;
         out_valid_q  <= out_valid_d;
         out_word_q   <= out_word_d;
         out_last_q   <= out_last_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         cnt_total_q  <= cnt_total_d;
         cnt_comp_q   <= cnt_comp_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_word  = out_word_q;
   assign bus.out_last  = out_last_q;
   assign cnt_total     = cnt_total_q;
   assign cnt_comp      = cnt_comp_q;
endmodule

// File: tb/tb_rvc_compressor_packer.sv
// Directed bench for rvc_compressor_packer: compression table, packing, flush,
// backpressure, pass-through build and mid-stream reset.
module tb_rvc_compressor_packer;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] a_total, a_comp, b_total, b_comp;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [32:0] mon_q[$];

   rvc_compressor_packer_if a ();
   rvc_compressor_packer_if b ();

   rvc_compressor_packer #(.ENABLE_COMPRESS(1'b1), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .bus(a), .cnt_total(a_total), .cnt_comp(a_comp)
   );
   rvc_compressor_packer #(.ENABLE_COMPRESS(1'b0), .CNT_W(16)) u_dut_nc (
      .clk(clk), .rst(rst), .bus(b), .cnt_total(b_total), .cnt_comp(b_comp)
   );

   always #5 clk = ~clk;

   // Records every output word of the compressing instance that will transfer next posedge
   always begin
      @(negedge clk);
      #2;
      if (rst && a.out_valid && a.out_ready) mon_q.push_back({a.out_last, a.out_word});
   end

   typedef struct packed {
      logic [31:0] instr;
      logic        is_c;
      logic [15:0] half;
   } vec_t;
   vec_t vecs [0:17];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [31:0] ins, input logic last);
      int n = 0;
      a.in_valid = 1'b1;
      a.in_instr = ins;
      a.in_last  = last;
      while (!a.in_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!a.in_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout: in_ready stuck low for instr 0x%08h", ins);
      end
      @(posedge clk);
      @(negedge clk);
      a.in_valid = 1'b0;
      a.in_last  = 1'b0;
   endtask

   task automatic expect_word(input string name, input logic [31:0] w, input logic l);
      int n = 0;
      logic [32:0] got;
      while (mon_q.size() == 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      n_cmp++;
      if (mon_q.size() == 0) begin
         n_bad++;
         $display("FAIL %s: no word emitted, expected last=%0b word=0x%08h", name, l, w);
      end else begin
         got = mon_q.pop_front();
         if (got !== {l, w}) begin
            n_bad++;
            $display("FAIL %s: got last=%0b word=0x%08h, expected last=%0b word=0x%08h",
                     name, got[32], got[31:0], l, w);
         end
      end
   endtask

   initial begin
      int exp_comp;
      a.in_valid = 1'b0; a.in_instr = 32'h0; a.in_last = 1'b0; a.out_ready = 1'b1;
      b.in_valid = 1'b0; b.in_instr = 32'h0; b.in_last = 1'b0; b.out_ready = 1'b1;

      vecs[0]  = '{32'h00000013, 1'b1, 16'h0001};  // c.nop
      vecs[1]  = '{32'h02040413, 1'b0, 16'h0000};  // addi x8,x8,32
      vecs[2]  = '{32'hFE040413, 1'b1, 16'h1401};  // addi x8,x8,-32
      vecs[3]  = '{32'h00040413, 1'b0, 16'h0000};  // addi x8,x8,0
      vecs[4]  = '{32'h00700513, 1'b1, 16'h451D};  // c.li x10,7
      vecs[5]  = '{32'h00B00533, 1'b1, 16'h852E};  // c.mv x10,x11
      vecs[6]  = '{32'h40940433, 1'b1, 16'h8C05};  // c.sub x8,x9
      vecs[7]  = '{32'h00A4F4B3, 1'b1, 16'h8CE9};  // c.and x9,x10
      vecs[8]  = '{32'h40345413, 1'b1, 16'h840D};  // c.srai x8,3
      vecs[9]  = '{32'h00429293, 1'b1, 16'h0292};  // c.slli x5,4
      vecs[10] = '{32'h00442803, 1'b0, 16'h0000};  // lw x16,4(x8)
      vecs[11] = '{32'h00942423, 1'b1, 16'hC404};  // c.sw x9,8(x8)
      vecs[12] = '{32'h00942123, 1'b0, 16'h0000};  // sw x9,2(x8)
      vecs[13] = '{32'h00812283, 1'b1, 16'h42A2};  // c.lwsp x5,8
      vecs[14] = '{32'h008002EF, 1'b0, 16'h0000};  // jal x5,8
      vecs[15] = '{32'hFFDFF06F, 1'b1, 16'hBFF5};  // c.j -4
      vecs[16] = '{32'h00040463, 1'b1, 16'hC401};  // c.beqz x8,8
      vecs[17] = '{32'hF00490E3, 1'b1, 16'hF081};  // c.bnez x9,-256

      repeat (3) @(negedge clk);
      check("rst_out_valid", 64'(a.out_valid), 64'd0);
      check("rst_out_word", 64'(a.out_word), 64'd0);
      check("rst_out_last", 64'(a.out_last), 64'd0);
      check("rst_cnt_total", 64'(a_total), 64'd0);
      check("rst_cnt_comp", 64'(a_comp), 64'd0);
      rst = 1'b1;
      @(negedge clk);
      check("rst_in_ready", 64'(a.in_ready), 64'd1);

      // Two compressed parcels share one word
      send(32'h00540413, 1'b0);
      check("pair_no_out", 64'(a.out_valid), 64'd0);
      check("pair_comp1", 64'(a_comp), 64'd1);
      send(32'h00B50533, 1'b0);
      check("pair_valid", 64'(a.out_valid), 64'd1);
      check("pair_word", 64'(a.out_word), 64'h952E0415);
      check("pair_total", 64'(a_total), 64'd2);
      expect_word("pair_mon", 32'h952E0415, 1'b0);

      // Straddling 32-bit instruction with in_last, then flush under backpressure
      send(32'h00442483, 1'b0);
      send(32'h123452B7, 1'b1);
      a.out_ready = 1'b0;
      check("flush_word1", 64'(a.out_word), 64'h52B74044);
      check("flush_last1", 64'(a.out_last), 64'd0);
      repeat (3) begin
         @(negedge clk);
         check("flush_in_ready", 64'(a.in_ready), 64'd0);
         check("flush_stable", 64'(a.out_word), 64'h52B74044);
      end
      a.out_ready = 1'b1;
      expect_word("flush_w1", 32'h52B74044, 1'b0);
      expect_word("flush_w2", 32'h00011234, 1'b1);
      check("flush_ready_back", 64'(a.in_ready), 64'd1);
      check("flush_total", 64'(a_total), 64'd4);
      check("flush_comp", 64'(a_comp), 64'd3);

      // Output stall with a pending input
      a.out_ready = 1'b0;
      send(32'h123452B7, 1'b0);
      a.in_valid = 1'b1; a.in_instr = 32'hABCDE2B7; a.in_last = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check("bp_in_ready", 64'(a.in_ready), 64'd0);
         check("bp_word", 64'(a.out_word), 64'h123452B7);
         check("bp_total", 64'(a_total), 64'd5);
      end
      a.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      a.in_valid = 1'b0;
      expect_word("bp_w1", 32'h123452B7, 1'b0);
      expect_word("bp_w2", 32'hABCDE2B7, 1'b0);
      check("bp_total_after", 64'(a_total), 64'd6);

      // Compression table, one single-instruction stream per vector
      exp_comp = 3;
      for (int i = 0; i < 18; i++) begin
         send(vecs[i].instr, 1'b1);
         expect_word($sformatf("vec%0d", i),
                     vecs[i].is_c ? {16'h0001, vecs[i].half} : vecs[i].instr, 1'b1);
         if (vecs[i].is_c) exp_comp++;
      end
      check("tbl_comp", 64'(a_comp), 64'(exp_comp));
      check("tbl_total", 64'(a_total), 64'd24);

      // Pass-through build
      b.in_valid = 1'b1; b.in_instr = 32'h00540413;
      check("nc_ready0", 64'(b.in_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      check("nc_valid0", 64'(b.out_valid), 64'd1);
      check("nc_word0", 64'(b.out_word), 64'h00540413);
      b.in_instr = 32'h00B50533;
      check("nc_ready1", 64'(b.in_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      b.in_valid = 1'b0;
      check("nc_word1", 64'(b.out_word), 64'h00B50533);
      check("nc_comp", 64'(b_comp), 64'd0);
      check("nc_total", 64'(b_total), 64'd2);

      // Reset with a held halfword and a stalled output word
      a.out_ready = 1'b0;
      send(32'h00442483, 1'b0);
      send(32'h123452B7, 1'b0);
      check("mr_pre_valid", 64'(a.out_valid), 64'd1);
      rst = 1'b0;
      @(negedge clk);
      check("mr_valid", 64'(a.out_valid), 64'd0);
      check("mr_total", 64'(a_total), 64'd0);
      check("mr_comp", 64'(a_comp), 64'd0);
      rst = 1'b1;
      a.out_ready = 1'b1;
      send(32'h123452B7, 1'b1);
      expect_word("mr_fresh", 32'h123452B7, 1'b1);
      repeat (3) @(negedge clk);
      check("no_extra_words", 64'(mon_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/rvc_compressor_packer.md
Name: rvc_compressor_packer

Overview:
- Streaming RV32C instruction compactor; the inverse of the fetch-side decompressor.
- Accepts 32-bit RV32I instructions one per handshake. Each instruction is replaced by its 16-bit RVC equivalent when one exists in the supported subset.
- Resulting 16/32-bit parcels are packed little-endian into 32-bit memory words for the instruction-image writer.
- Branch/jump offsets are encoded exactly as given; offset relocation is upstream's job.

Parameters:
- ENABLE_COMPRESS, 1, 0 = pass every instruction through as 32-bit (packer still active).
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- in_valid  in  1  input instruction valid
- in_ready  out  1  block accepts input this cycle
- in_instr  in  32  uncompressed RV32I instruction
- in_last  in  1  final instruction of the stream; flush after it
- out_valid  out  1  packed word valid
- out_ready  in  1  downstream accepts word
- out_word  out  32  packed word; first parcel in [15:0]
- out_last  out  1  final word of the stream
- cnt_total  out  CNT_W  instructions accepted
- cnt_comp  out  CNT_W  instructions emitted as 16-bit

Behaviour:
- Reset (rst==0 at posedge): out_valid=0, out_word=0, out_last=0, hold_valid=0, hold=0, state=RUN, both counters 0.
- Reset mid-stream discards the held halfword and any pending output word.
- Compression rules, combinational on in_instr. Anything unmatched, or any match while ENABLE_COMPRESS=0, stays 32-bit.
  - addi x0,x0,0 -> c.nop 0x0001.
  - addi rd,rd,imm with rd!=0, imm!=0, imm in [-32,31] -> c.addi.
  - addi rd,x0,imm with rd!=0, imm in [-32,31] -> c.li.
  - add rd,x0,rs2 with rd,rs2!=0 -> c.mv.
  - add rd,rd,rs2 with rd,rs2!=0 -> c.add.
  - sub/xor/or/and rd,rd,rs2 with rd,rs2 in x8..x15 -> c.sub/c.xor/c.or/c.and.
  - andi rd,rd,imm with rd in x8..x15, imm in [-32,31] -> c.andi.
  - srli/srai rd,rd,sh with rd in x8..x15, sh!=0 -> c.srli/c.srai.
  - slli rd,rd,sh with rd!=0, sh!=0 -> c.slli.
  - lw/sw with rd/rs2 and rs1 in x8..x15, offset%4==0, offset in 0..124 -> c.lw/c.sw.
  - lw rd!=0 / sw with rs1=x2, offset%4==0, offset in 0..252 -> c.lwsp/c.swsp.
  - jal x0/x1 with offset in [-2048,2046] -> c.j/c.jal.
  - beq/bne rs1,x0 with rs1 in x8..x15, offset in [-256,254] -> c.beqz/c.bnez.
- Handshakes:
  - in_ready = (state==RUN) && (!out_valid || out_ready).
  - An input transfers when in_valid && in_ready.
  - out_word/out_last stay stable while out_valid && !out_ready.
- Packing on transfer; c = 16-bit parcel, w = 32-bit instruction:
  - no hold, c: hold<=c, hold_valid<=1, no output.
  - no hold, w: out_word<=w.
  - hold, c: out_word<={c,hold}, hold_valid<=0.
  - hold, w: out_word<={w[15:0],hold}, hold<=w[31:16], hold_valid stays 1.
  - In every output case out_valid<=1, with latency 1 cycle.
- in_last handling:
  - If hold_valid is 0 after the transfer: the word emitted by that transfer carries out_last=1. If that transfer emitted no word, hold is non-zero by construction.
  - If hold_valid is 1 after the transfer: go to FLUSH. FLUSH waits for the output slot to be free, then emits {16'h0001, hold} with out_last=1, clears hold, and returns to RUN.
  - in_ready is 0 throughout FLUSH.
- Counters increment on every transfer (cnt_total) and on every 16-bit transfer (cnt_comp), saturating at all-ones.
- Output register is cleared (out_valid<=0) on out_ready unless a new word is loaded the same cycle. Load wins when both happen.

Test Plan:
- Reset, then addi x8,x8,5 (0x00540413): no output, cnt_comp=1. Then add x10,x10,x11 (0x00B50533): out_word=0x952E0415 one cycle after transfer, cnt_total=2.
- With empty hold, lw x9,4(x8) (0x00442483) -> held 0x4044. Then lui x5,0x12345 (0x123452B7) with in_last=1 -> out_word=0x52B74044, out_last=0. Then FLUSH word 0x00011234 with out_last=1; in_ready=0 until it is accepted.
- Hold out_ready=0 for 5 cycles with valid input pending: in_ready=0, out_word stable, counters frozen. Release: one word per cycle, no loss.
- ENABLE_COMPRESS=0, stream 0x00540413 then 0x00B50533 -> out_word 0x00540413, then 0x00B50533; cnt_comp=0.
- Boundaries that must stay 32-bit and must not be compressed: addi x8,x8,32; lw x16,4(x8); sw with offset 2; jal x5.
- Assert rst=0 while hold_valid=1 and out_valid=1 -> next cycle out_valid=0, counters 0. A fresh 32-bit input emits unshifted, with no stale halfword.
